// File: rtl/sum_arbiter_pkg.sv
// sum_arbiter_pkg: shared FSM state and requester index types
package sum_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic req_idx_t;
endpackage

// File: rtl/sum_datapath.sv
// sum_datapath: 8-bit wrapping accumulator and nonzero word counter
module sum_datapath (
    input  logic       ck,
    input  logic       reset_l,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] word,
    output logic [7:0] sum,
    output logic [7:0] count
);
    logic [7:0] sum_q, sum_d, count_q, count_d;
    // clear wins over accumulate so a new job always starts from zero
    always_comb begin
        sum_d   = clear ? 8'd0 : add_en ? sum_q + word : sum_q;
        count_d = clear ? 8'd0 : add_en ? count_q + 8'd1 : count_q;
    end
    // accumulator and counter registers
    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            sum_q   <= 8'd0;
            count_q <= 8'd0;
        end else begin
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end
    assign sum   = sum_q;
    assign count = count_q;
endmodule

// File: rtl/sum_arbiter.sv
// sum_arbiter: round-robin two-requester arbiter that sums each job's words
module sum_arbiter
    import sum_arbiter_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic       ck,
    input  logic       reset_l,
    input  logic       req0_l,
    input  logic       req1_l,
    input  logic [7:0] inA0,
    input  logic [7:0] inA1,
    output logic [1:0] gnt,
    output logic       done0,
    output logic       done1,
    output logic [7:0] outResult,
    output logic       timeout,
    output logic       busy
);
    localparam logic [7:0] LAST = 8'(MAX_LEN - 1);
    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d, done_q, done_d;
    logic [7:0] result_q, result_d, word, sum, count;
    logic       timeout_q, timeout_d, clear, add_en, pend0, pend1;
    req_idx_t   last_q, last_d, win;

    assign pend0 = ~req0_l;
    assign pend1 = ~req1_l;

    sum_datapath u_dp (
        .ck      (ck),
        .reset_l (reset_l),
        .clear   (clear),
        .add_en  (add_en),
        .word    (word),
        .sum     (sum),
        .count   (count)
    );

    // next-state, arbitration and completion logic
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = 2'b00;
        result_d  = result_q;
        timeout_d = timeout_q;
        last_d    = last_q;
        clear     = 1'b0;
        add_en    = 1'b0;
        win       = (pend0 && pend1) ? ~last_q : pend1;
        word      = gnt_q[1] ? inA1 : inA0;
        case (state_q)
            IDLE: begin
                if (pend0 || pend1) begin
                    state_d = RUN;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (word == 8'd0) begin
                    state_d   = DONE;
                    done_d    = gnt_q;
                    result_d  = sum;
                    timeout_d = 1'b0;
                end else begin
                    add_en = 1'b1;
                    if (count == LAST) begin
                        state_d   = DONE;
                        done_d    = gnt_q;
                        result_d  = sum + word;
                        timeout_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                last_d  = gnt_q[1];
            end
            default: state_d = IDLE;
        endcase
    end

    // control and output registers; reset aborts any job silently
    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            result_q  <= 8'd0;
            timeout_q <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign outResult = result_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sum_arbiter.sv
// tb_sum_arbiter: scoreboard bench with behavioural requesters and job-sum model
module tb_sum_arbiter;
    localparam int MAX_LEN = 16;

    typedef struct {
        logic [7:0] sum;
        logic       to;
    } exp_t;

    logic       ck = 1'b0;
    logic       reset_l = 1'b0;
    logic       req0_l = 1'b1;
    logic       req1_l = 1'b1;
    logic [7:0] inA0 = 8'd0;
    logic [7:0] inA1 = 8'd0;
    logic [7:0] outResult;
    logic [1:0] gnt;
    logic       done0, done1, timeout, busy;

    int checks = 0;
    int errors = 0;

    exp_t       exp0[$];
    exp_t       exp1[$];
    logic [7:0] words[2][32];
    int         len[2], idx[2], cnt[2];
    logic       act[2], due[2], rel[2];

    sum_arbiter #(.MAX_LEN(MAX_LEN)) dut (
        .ck        (ck),
        .reset_l   (reset_l),
        .req0_l    (req0_l),
        .req1_l    (req1_l),
        .inA0      (inA0),
        .inA1      (inA1),
        .gnt       (gnt),
        .done0     (done0),
        .done1     (done1),
        .outResult (outResult),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 ck = ~ck;

    // Job result from the rules: sum nonzero words mod 256 until a zero word or MAX_LEN words
    function automatic exp_t model(input int i);
        exp_t e;
        int   n;
        e.sum = 8'd0;
        e.to  = 1'b0;
        n     = 0;
        for (int j = 0; j < len[i]; j++) begin
            if (words[i][j] == 8'd0) break;
            e.sum = e.sum + words[i][j];
            n++;
            if (n == MAX_LEN) begin
                e.to = 1'b1;
                break;
            end
        end
        return e;
    endfunction

    task automatic set_req(input int i, input logic v);
        if (i == 0) req0_l = v;
        else req1_l = v;
    endtask

    task automatic launch(input int i);
        act[i] = 1'b1;
        due[i] = 1'b0;
        idx[i] = 0;
        cnt[i] = 0;
        if (i == 0) exp0.push_back(model(0));
        else exp1.push_back(model(1));
        set_req(i, 1'b0);
    endtask

    task automatic start3(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        words[i][0] = a;
        words[i][1] = b;
        words[i][2] = c;
        len[i] = 3;
        launch(i);
    endtask

    task automatic start_fill(input int i, input logic [7:0] v, input int n);
        for (int j = 0; j < n; j++) words[i][j] = v;
        len[i] = n;
        launch(i);
    endtask

    task automatic start_rand(input int i);
        int n;
        if ($urandom_range(3) == 0) begin
            for (int j = 0; j < 20; j++) words[i][j] = 8'($urandom_range(1, 255));
            len[i] = 20;
        end else begin
            n = $urandom_range(0, 8);
            for (int j = 0; j < n; j++) words[i][j] = 8'($urandom_range(1, 255));
            words[i][n] = 8'd0;
            len[i] = n + 1;
        end
        launch(i);
    endtask

    // One clock of requester behaviour: check done timing, consume words, release, drive data
    task automatic step();
        logic [1:0] g, d;
        logic [7:0] w;
        @(negedge ck);
        g = gnt;
        d = {done1, done0};
        @(posedge ck);
        #1;
        for (int i = 0; i < 2; i++) begin
            rel[i] = 1'b0;
            if (act[i] || d[i]) begin
                checks++;
                if (d[i] !== due[i]) begin
                    errors++;
                    $display("FAIL done%0d_timing: got %b expected %b at %0t", i, d[i], due[i], $time);
                end
            end
            if (act[i] && (d[i] || due[i])) begin
                act[i] = 1'b0;
                due[i] = 1'b0;
                rel[i] = 1'b1;
                set_req(i, 1'b1);
            end else if (act[i] && g[i]) begin
                w = words[i][idx[i]];
                idx[i]++;
                if (w != 8'd0) cnt[i]++;
                due[i] = (w == 8'd0) || (cnt[i] == MAX_LEN);
            end
        end
        inA0 = (act[0] && gnt[0] && idx[0] < len[0]) ? words[0][idx[0]] : 8'($urandom);
        inA1 = (act[1] && gnt[1] && idx[1] < len[1]) ? words[1][idx[1]] : 8'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((act[0] || act[1]) && k < bound) begin
            step();
            k++;
        end
        checks++;
        if (act[0] || act[1]) begin
            errors++;
            $display("FAIL job_completion: requesters still active %b%b after %0d cycles", act[1], act[0], bound);
            act[0] = 1'b0;
            act[1] = 1'b0;
            set_req(0, 1'b1);
            set_req(1, 1'b1);
        end
        step();
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            due[i] = 1'b0;
            set_req(i, 1'b1);
        end
        exp0.delete();
        exp1.delete();
        repeat (2) step();
        reset_l = 1'b1;
    endtask

    // Monitor: reset values, one-hot grant, round-robin decisions, completion scoreboard
    initial begin
        logic [1:0] pg, pr, eg;
        logic       pv, last;
        exp_t       e;
        pv   = 1'b0;
        last = 1'b1;
        pg   = 2'b00;
        pr   = 2'b00;
        forever begin
            @(negedge ck);
            if (!reset_l) begin
                checks++;
                if ({gnt, done1, done0, outResult, timeout, busy} !== 14'd0) begin
                    errors++;
                    $display("FAIL reset_values: gnt=%b done=%b%b result=%0d timeout=%b busy=%b expected all 0",
                             gnt, done1, done0, outResult, timeout, busy);
                end
                pv   = 1'b0;
                last = 1'b1;
            end else begin
                checks++;
                if (gnt == 2'b11 || busy !== (gnt != 2'b00)) begin
                    errors++;
                    $display("FAIL grant_onehot_busy: gnt=%b busy=%b expected one-hot gnt with busy=|gnt", gnt, busy);
                end
                if (pv && pg == 2'b00) begin
                    eg = (pr == 2'b11) ? (last ? 2'b01 : 2'b10) : pr;
                    checks++;
                    if (gnt !== eg) begin
                        errors++;
                        $display("FAIL arbitration: gnt=%b expected %b (pending %b last %0d)", gnt, eg, pr, last);
                    end
                end
                if (done0 || done1) begin
                    checks++;
                    if ((done0 && done1) || gnt !== {done1, done0}) begin
                        errors++;
                        $display("FAIL done_grant: done=%b%b gnt=%b expected single done matching gnt", done1, done0, gnt);
                    end
                    if ((done1 ? exp1.size() : exp0.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done%0d with no job outstanding", done1);
                    end else begin
                        e = done1 ? exp1.pop_front() : exp0.pop_front();
                        checks++;
                        if (outResult !== e.sum) begin
                            errors++;
                            $display("FAIL result%0d: got %0d expected %0d", done1, outResult, e.sum);
                        end
                        checks++;
                        if (timeout !== e.to) begin
                            errors++;
                            $display("FAIL timeout%0d: got %b expected %b", done1, timeout, e.to);
                        end
                    end
                    last = done1;
                end
                pg = gnt;
                pr = {~req1_l, ~req0_l};
                pv = 1'b1;
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;
            due[i] = 1'b0;
            rel[i] = 1'b0;
            len[i] = 0;
            idx[i] = 0;
            cnt[i] = 0;
        end
        repeat (3) step();
        reset_l = 1'b1;
        step();
        start3(0, 8'd5, 8'd7, 8'd0);
        wait_idle(50);
        start3(0, 8'd200, 8'd100, 8'd0);
        wait_idle(50);
        start_fill(1, 8'd1, 20);
        wait_idle(50);
        start3(0, 8'd0, 8'd0, 8'd0);
        wait_idle(50);
        do_reset();
        start_rand(0);
        start_rand(1);
        k = 0;
        while (act[0] && k < 50) begin
            step();
            k++;
        end
        step();
        start_rand(0);
        wait_idle(100);
        start3(0, 8'd9, 8'd9, 8'd0);
        k = 0;
        while (!(act[0] && idx[0] == 1) && k < 50) begin
            step();
            k++;
        end
        do_reset();
        step();
        start3(0, 8'd3, 8'd4, 8'd0);
        wait_idle(50);
        repeat (400) begin
            step();
            for (int i = 0; i < 2; i++)
                if (!act[i] && !rel[i] && $urandom_range(2) == 0) start_rand(i);
        end
        wait_idle(200);
        repeat (3) step();
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d jobs never completed, expected 0/0", exp0.size(), exp1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sum_arbiter.md
SUM_ARBITER -- requirements
Module: sum_arbiter

Interface
REQ-001 Parameter MAX_LEN, default 16, meaning the maximum number of nonzero words summed per job before forced completion (legal range 1..255).
REQ-002 ck  input  1  the single clock; all state updates on posedge ck.
REQ-003 reset_l  input  1  asynchronous, active-low reset.
REQ-004 req0_l, req1_l  input  1 each  active-low level requests; each is held low until that requester's done pulse.
REQ-005 inA0, inA1  input  8 each  data word from each requester; sampled only while that requester is granted and in RUN.
REQ-006 gnt  output  2  registered one-hot grant, gnt[i] for requester i; 2'b00 when idle.
REQ-007 done0, done1  output  1 each  registered one-cycle completion pulse to the served requester.
REQ-008 outResult  output  8  registered sum of the last completed job; holds until the next completion.
REQ-009 timeout  output  1  registered; valid with done, 1 when the job ended by MAX_LEN rather than by a zero word.
REQ-010 busy  output  1  1 whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE: with no request pending, stay IDLE; with any request pending, select a winner, set gnt to the winner, clear the accumulator and word count, go to RUN.
REQ-013 Arbitration SHALL be round-robin: a single request wins; if both requests are pending, the requester not served last wins; after reset requester 0 has priority.
REQ-014 RUN: each cycle, sample the granted requester's word; if it is zero, go to DONE without updating the accumulator.
REQ-015 RUN nonzero word: acc <= (acc + word) mod 256 (8-bit wrap, no saturation, no carry output); count <= count + 1.
REQ-016 RUN: if the nonzero word just added is the MAX_LEN-th, go to DONE with timeout = 1; otherwise stay in RUN.
REQ-017 On the RUN->DONE transition: load outResult with the final sum (including the last word when timing out); timeout is 0 on zero-termination.
REQ-018 DONE SHALL last exactly one cycle: done[i] = 1 for the granted i only, gnt held; then go to IDLE, clear gnt, record i as last served.
REQ-019 Latency: request seen in IDLE at cycle t -> gnt at t+1 (the first word is sampled at t+1); zero word at cycle z -> done at z+1; IDLE again at z+2.
REQ-020 Requester release: a requester raises req_l on the clock edge after it sees its done; requests are sampled only in IDLE, so a raised request is never re-granted.
REQ-021 Request deassertion during RUN SHALL be ignored; the job runs to zero-termination or timeout.
REQ-022 The non-granted requester's data SHALL be ignored; its pending request waits and is served on the next IDLE cycle.
REQ-023 The zero word SHALL never be counted toward MAX_LEN.

Reset
REQ-024 While reset_l = 0: state = IDLE, gnt = 0, done0 = done1 = 0, outResult = 0, timeout = 0, busy = 0, accumulator = 0, count = 0, last-served = requester 1 (so requester 0 wins first).
REQ-025 Reset asserted mid-job SHALL abort the job immediately with no done pulse; after release the FSM starts in IDLE.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the requester-index type.
REQ-027 The accumulator and word counter SHALL be one sub-module, sum_datapath (controls: clear, add_en; outputs: sum, count), with the FSM and arbiter in sum_arbiter.

Verification
REQ-028 Single job: req0_l low at cycle 0; words 5, 7, 0 at cycles 1-3 -> gnt = 01 cycles 1-4; done0 = 1 at cycle 4; outResult = 12; timeout = 0.
REQ-029 Wrap: words 200, 100, 0 -> outResult = 44, timeout = 0.
REQ-030 Timeout: MAX_LEN = 16; requester 1 sends 1 continuously -> done1 = 1 one cycle after the 16th word; outResult = 16; timeout = 1.
REQ-031 Contention: both requests held from reset release -> requester 0 served first, then requester 1; with both requests still held, requester 0 next; gnt is never 11.
REQ-032 Immediate zero: first granted word = 0 -> done the next cycle; outResult = 0; timeout = 0.
REQ-033 Reset mid-RUN: assert reset_l low during word 2 -> gnt, done and outResult are 0 immediately; no done pulse; a fresh job after release gives the correct sum.
